// File: rtl/uart_rx_oversampled_if.sv
// Output-side bundle of the oversampled UART receiver: received word,
// its status flags and the valid/ready handshake with the consumer.
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid_data;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    // Receiver side: produces the word and flags, observes ready.
    modport master (
        output data,
        output valid_data,
        output parity_err,
        output frame_err,
        output overrun,
        input  ready
    );

    // Consumer side: observes the word and flags, drives ready.
    modport slave (
        input  data,
        input  valid_data,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop synchronizer, falling-edge start
// detection with mid-bit false-start rejection, configurable data width,
// parity and stop bits, and a one-entry holding register with overrun
// reporting on the valid/ready side.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  uart_rx,
    uart_rx_oversampled_if.master bus,
    output logic                  busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    // Tick count at the centre of the start bit, and at every later bit centre.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CNT_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr;
    logic                 ferr;
    logic                 commit;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame state machine; everything here advances only on sample ticks,
    // including rx_prev, so edge detection stays consistent with the tick rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rx_prev   <= 1'b1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            commit    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (sample_tick) begin
                rx_prev <= rx_s;
                case (state)
                    S_IDLE: begin
                        // Only a high-to-low transition starts a frame, so a
                        // line stuck low after a framing error cannot re-trigger.
                        if (!rx_s && rx_prev) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tick_cnt == HALF_LAST) begin
                            if (rx_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= S_DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                                perr     <= 1'b0;
                                ferr     <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            if (bit_idx == IDX_LAST) begin
                                state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                                stop_idx <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            perr     <= ((^shift_reg) ^ rx_s) != (PARITY == 1);
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                ferr <= 1'b1;
                            end
                            // Return to IDLE right at the last stop centre so a
                            // back-to-back start edge is not missed.
                            if (stop_idx == STOP_LAST) begin
                                state  <= S_IDLE;
                                busy   <= 1'b0;
                                commit <= 1'b1;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register: a commit loads a new word (flagging overrun if the
    // previous one was never taken); an accept without a commit empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data       <= '0;
            bus.valid_data <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (commit) begin
            bus.data       <= shift_reg;
            bus.parity_err <= perr;
            bus.frame_err  <= ferr;
            bus.overrun    <= bus.valid_data & ~bus.ready;
            bus.valid_data <= 1'b1;
        end else if (bus.valid_data && bus.ready) begin
            bus.valid_data <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: one instance with default parameters and
// sample_tick tied high, one with even parity, two stop bits and a tick on
// every other clock. Frames are built from their bit-level definition and
// received words are compared with the expected word and flags.
module tb_uart_rx_oversampled;
    localparam int CPB0 = 16;   // clocks per bit, instance 0
    localparam int CPB1 = 32;   // clocks per bit, instance 1 (tick every 2nd clk)

    logic clk   = 1'b0;
    logic tick1 = 1'b0;
    logic rst;
    logic rx0, rx1;
    logic ready0, ready1;
    logic busy0, busy1;

    int vectors     = 0;
    int miscompares = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus1 ();

    assign bus0.ready = ready0;
    assign bus1.ready = ready1;

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)
    ) u0 (
        .clk(clk), .rst(rst), .sample_tick(1'b1), .uart_rx(rx0),
        .bus(bus0), .busy(busy0)
    );

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)
    ) u1 (
        .clk(clk), .rst(rst), .sample_tick(tick1), .uart_rx(rx1),
        .bus(bus1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick1 <= ~tick1;

    // Record every accepted word as {overrun, frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (bus0.valid_data && bus0.ready)
            q0.push_back({bus0.overrun, bus0.frame_err, bus0.parity_err, bus0.data});
        if (bus1.valid_data && bus1.ready)
            q1.push_back({bus1.overrun, bus1.frame_err, bus1.parity_err, bus1.data});
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line sequence of a frame, bit 0 first: start, data LSB first,
    // optional parity bit, then the stop bits.
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input bit has_par,
                                             input logic pbit, input int nstop,
                                             input logic [1:0] stops);
        logic [15:0] b;
        int k;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        k = 9;
        if (has_par) begin
            b[k] = pbit;
            k++;
        end
        for (int s = 0; s < nstop; s++) b[k + s] = stops[s];
        return b;
    endfunction

    // Parity error rule: count all ones including the parity bit.
    function automatic logic exp_perr(input logic [7:0] d, input logic pbit, input int mode);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (mode == 1) return (ones % 2) != 1;
        if (mode == 2) return (ones % 2) != 0;
        return 1'b0;
    endfunction

    task automatic send(input int which, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i];
            else            rx1 = bits[i];
            clks(cpb);
        end
    endtask

    task automatic expect_word(input int which, input logic [7:0] d, input logic pe,
                               input logic fe, input logic ov, input string tag);
        logic [10:0] got;
        int n;
        n = (which == 0) ? q0.size() : q1.size();
        chk({tag, ".count"}, 32'(n), 32'd1);
        if (n > 0) begin
            if (which == 0) got = q0.pop_front();
            else            got = q1.pop_front();
            chk({tag, ".data"}, 32'(got[7:0]), 32'(d));
            chk({tag, ".parity_err"}, 32'(got[8]), 32'(pe));
            chk({tag, ".frame_err"}, 32'(got[9]), 32'(fe));
            chk({tag, ".overrun"}, 32'(got[10]), 32'(ov));
        end
        if (which == 0) q0.delete();
        else            q1.delete();
    endtask

    task automatic frame0(input logic [7:0] d, input logic stop_ok, input string tag);
        send(0, mk_frame(d, 1'b0, 1'b0, 1, {1'b1, stop_ok}), 10, CPB0);
        rx0 = 1'b1;
        clks(2 * CPB0);
        expect_word(0, d, 1'b0, ~stop_ok, 1'b0, tag);
    endtask

    task automatic frame1(input logic [7:0] d, input logic pbit, input logic [1:0] stops,
                          input string tag);
        send(1, mk_frame(d, 1'b1, pbit, 2, stops), 12, CPB1);
        rx1 = 1'b1;
        clks(2 * CPB1);
        expect_word(1, d, exp_perr(d, pbit, 2), (stops != 2'b11), 1'b0, tag);
    endtask

    initial begin
        logic [7:0]  d;
        logic [1:0]  st;
        logic [15:0] bits;

        rst    = 1'b1;
        rx0    = 1'b1;
        rx1    = 1'b1;
        ready0 = 1'b1;
        ready1 = 1'b1;
        clks(3);
        chk("reset.valid0", 32'(bus0.valid_data), 32'd0);
        chk("reset.data0",  32'(bus0.data),       32'd0);
        chk("reset.flags0", 32'({bus0.parity_err, bus0.frame_err, bus0.overrun}), 32'd0);
        chk("reset.busy0",  32'(busy0),           32'd0);
        chk("reset.valid1", 32'(bus1.valid_data), 32'd0);
        chk("reset.busy1",  32'(busy1),           32'd0);
        rst = 1'b0;
        clks(CPB0);

        // Basic frame at default settings.
        frame0(8'h4B, 1'b1, "basic");

        // Even parity with a wrong, then a correct, parity bit.
        frame1(8'h4B, 1'b1, 2'b11, "par_bad");
        frame1(8'h4B, 1'b0, 2'b11, "par_ok");

        // Framing error, then the line stays low for three bit times.
        send(0, mk_frame(8'hA5, 1'b0, 1'b0, 1, 2'b00), 10, CPB0);
        clks(3 * CPB0);
        expect_word(0, 8'hA5, 1'b0, 1'b1, 1'b0, "ferr");
        chk("ferr.held_low.busy",  32'(busy0),           32'd0);
        chk("ferr.held_low.valid", 32'(bus0.valid_data), 32'd0);
        rx0 = 1'b1;
        clks(CPB0);
        frame0(8'h3C, 1'b1, "after_ferr");

        // Short low glitch must be rejected.
        rx0 = 1'b0;
        clks(4);
        rx0 = 1'b1;
        clks(2 * CPB0);
        chk("glitch.busy",  32'(busy0),    32'd0);
        chk("glitch.count", 32'(q0.size()), 32'd0);
        frame0(8'h3C, 1'b1, "after_glitch");

        // Overrun with the consumer stalled.
        ready0 = 1'b0;
        send(0, mk_frame(8'h4B, 1'b0, 1'b0, 1, 2'b11), 10, CPB0);
        rx0 = 1'b1;
        clks(2 * CPB0);
        chk("ovr.first.valid", 32'(bus0.valid_data), 32'd1);
        chk("ovr.first.data",  32'(bus0.data),       32'h4B);
        chk("ovr.first.ovr",   32'(bus0.overrun),    32'd0);
        send(0, mk_frame(8'hA5, 1'b0, 1'b0, 1, 2'b11), 10, CPB0);
        rx0 = 1'b1;
        clks(2 * CPB0);
        chk("ovr.second.valid", 32'(bus0.valid_data), 32'd1);
        chk("ovr.second.data",  32'(bus0.data),       32'hA5);
        chk("ovr.second.ovr",   32'(bus0.overrun),    32'd1);
        ready0 = 1'b1;
        clks(1);
        ready0 = 1'b0;
        chk("ovr.accept.valid", 32'(bus0.valid_data), 32'd0);
        chk("ovr.accept.ovr",   32'(bus0.overrun),    32'd0);
        expect_word(0, 8'hA5, 1'b0, 1'b0, 1'b1, "ovr.taken");
        ready0 = 1'b1;

        // Reset in the middle of the 4th data bit.
        bits = mk_frame(8'h4B, 1'b0, 1'b0, 1, 2'b11);
        send(0, bits, 4, CPB0);
        rx0 = bits[4];
        clks(CPB0 / 2);
        chk("rst_mid.busy_before", 32'(busy0), 32'd1);
        rst = 1'b1;
        clks(1);
        chk("rst_mid.busy",  32'(busy0),           32'd0);
        chk("rst_mid.valid", 32'(bus0.valid_data), 32'd0);
        rst = 1'b0;
        rx0 = 1'b1;
        clks(2 * CPB0);
        chk("rst_mid.no_word", 32'(q0.size()), 32'd0);
        frame0(8'h3C, 1'b1, "after_rst");

        // Randomized frames on both instances.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            frame0(d, ($urandom_range(0, 3) != 0), "rand0");
            clks($urandom_range(0, 20));
        end
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            frame1(d, 1'($urandom_range(0, 1)), st, "rand1");
            clks($urandom_range(0, 20));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
